// File: rtl/branch_predictor.sv
// Direct-mapped BHT/BTB with 2-bit saturating counters. Lookup is combinational;
// resolution updates the table and raises a registered redirect on a mispredict.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        resolve_valid,
    input  logic        resolve_is_branch,
    input  logic [31:0] resolve_pc,
    input  logic        branch_result,
    input  logic [31:0] resolve_target,
    input  logic        resolve_pred_taken,
    input  logic [31:0] resolve_pred_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] mispredict_count
);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0]            valid_vec;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_vec;
    logic [ENTRIES-1:0][31:0]      target_vec;
    logic [ENTRIES-1:0][1:0]       ctr_vec;

    logic [IDX_W-1:0] f_idx, r_idx;
    logic [TAG_W-1:0] f_tag, r_tag;
    logic             f_hit, r_hit, upd;

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[31:IDX_W+2];
    assign r_idx = resolve_pc[IDX_W+1:2];
    assign r_tag = resolve_pc[31:IDX_W+2];
    assign upd   = resolve_valid & resolve_is_branch;

    assign f_hit       = valid_vec[f_idx] && (tag_vec[f_idx] == f_tag);
    assign r_hit       = valid_vec[r_idx] && (tag_vec[r_idx] == r_tag);
    assign pred_taken  = f_hit & ctr_vec[f_idx][1];
    assign pred_target = pred_taken ? target_vec[f_idx] : fetch_pc + 32'd4;

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             valid_q, valid_d;
            logic [TAG_W-1:0] tag_q, tag_d;
            logic [31:0]      target_q, target_d;
            logic [1:0]       ctr_q, ctr_d;
            logic             sel;

            assign sel = upd && (r_idx == IDX_W'(gi));

            always_comb begin
                valid_d  = valid_q;
                tag_d    = tag_q;
                target_d = target_q;
                ctr_d    = ctr_q;
                if (sel) begin
                    if (r_hit) begin
                        if (branch_result) begin
                            target_d = resolve_target;
                            if (ctr_q != 2'b11) ctr_d = ctr_q + 2'd1;
                        end else if (ctr_q != 2'b00) begin
                            ctr_d = ctr_q - 2'd1;
                        end
                    end else if (branch_result) begin
                        // Taken miss evicts whatever occupied this slot
                        valid_d  = 1'b1;
                        tag_d    = r_tag;
                        target_d = resolve_target;
                        ctr_d    = 2'b10;
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    valid_q  <= 1'b0;
                    tag_q    <= '0;
                    target_q <= '0;
                    ctr_q    <= 2'b01;
                end else begin
                    valid_q  <= valid_d;
                    tag_q    <= tag_d;
                    target_q <= target_d;
                    ctr_q    <= ctr_d;
                end
            end

            assign valid_vec[gi]  = valid_q;
            assign tag_vec[gi]    = tag_q;
            assign target_vec[gi] = target_q;
            assign ctr_vec[gi]    = ctr_q;
        end
    endgenerate

    logic [31:0] actual_next, predicted_next;
    logic        mispredict;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] count_q, count_d;

    // Compare full next-PCs so a right direction with a stale target still flushes
    assign actual_next    = branch_result ? resolve_target : resolve_pc + 32'd4;
    assign predicted_next = resolve_pred_taken ? resolve_pred_target : resolve_pc + 32'd4;
    assign mispredict     = upd && (actual_next != predicted_next);

    always_comb begin
        redirect_d    = mispredict;
        redirect_pc_d = redirect_pc_q;
        count_d       = count_q;
        if (mispredict) begin
            redirect_pc_d = actual_next;
            if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            count_q       <= '0;
        end else begin
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            count_q       <= count_d;
        end
    end

    assign redirect         = redirect_q;
    assign redirect_pc      = redirect_pc_q;
    assign mispredict_count = count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scenarios plus random traffic against a table-level reference model.
module tb_branch_predictor;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        resolve_valid, resolve_is_branch, branch_result, resolve_pred_taken;
    logic [31:0] resolve_pc, resolve_target, resolve_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc, mispredict_count;

    always #5 clock = ~clock;

    branch_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset(reset), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .resolve_valid(resolve_valid), .resolve_is_branch(resolve_is_branch),
        .resolve_pc(resolve_pc), .branch_result(branch_result),
        .resolve_target(resolve_target), .resolve_pred_taken(resolve_pred_taken),
        .resolve_pred_target(resolve_pred_target),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .mispredict_count(mispredict_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: tables indexed by word address modulo ENTRIES
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    bit          m_redir;
    logic [31:0] m_rpc;
    logic [31:0] m_cnt;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic bit hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == int'(pc / (4 * ENTRIES)));
    endfunction

    task automatic model_pred(input logic [31:0] pc, output bit t, output logic [31:0] tg);
        t  = hit(pc) && (m_ctr[slot(pc)] >= 2);
        tg = t ? m_tgt[slot(pc)] : pc + 32'd4;
    endtask

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_redir = 0; m_rpc = 0; m_cnt = 0;
    endtask

    task automatic step();
        bit          et;
        logic [31:0] etg, act, prd;
        int          s;
        @(negedge clock);
        model_pred(fetch_pc, et, etg);
        chk("pred_taken", 32'(pred_taken), 32'(et));
        chk("pred_target", pred_target, etg);
        if (reset) begin
            model_clear();
        end else begin
            m_redir = 0;
            if (resolve_valid && resolve_is_branch) begin
                act = branch_result ? resolve_target : resolve_pc + 32'd4;
                prd = resolve_pred_taken ? resolve_pred_target : resolve_pc + 32'd4;
                s = slot(resolve_pc);
                if (hit(resolve_pc)) begin
                    if (branch_result) begin
                        m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                        m_tgt[s] = resolve_target;
                    end else begin
                        m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                    end
                end else if (branch_result) begin
                    m_valid[s] = 1;
                    m_tag[s]   = int'(resolve_pc / (4 * ENTRIES));
                    m_tgt[s]   = resolve_target;
                    m_ctr[s]   = 2;
                end
                if (act != prd) begin
                    m_redir = 1;
                    m_rpc   = act;
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                end
            end
        end
        @(posedge clock);
        #1;
        chk("redirect", 32'(redirect), 32'(m_redir));
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("mispredict_count", mispredict_count, m_cnt);
        n_txn++;
        $display("txn %0d rst=%0b fetch=%h res=%0b%0b pc=%h br=%0b tgt=%h ppt=%0b ptg=%h -> redir=%0b rpc=%h cnt=%0d",
                 n_txn, reset, fetch_pc, resolve_valid, resolve_is_branch, resolve_pc, branch_result,
                 resolve_target, resolve_pred_taken, resolve_pred_target, redirect, redirect_pc, mispredict_count);
    endtask

    task automatic go(input bit rst, input logic [31:0] f, input bit rv, input logic [31:0] rpc,
                      input bit br, input logic [31:0] rt, input bit pt, input logic [31:0] ptg);
        reset = rst; fetch_pc = f; resolve_valid = rv; resolve_is_branch = 1'b1;
        resolve_pc = rpc; branch_result = br; resolve_target = rt;
        resolve_pred_taken = pt; resolve_pred_target = ptg;
        step();
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
        return (32'($urandom_range(0, 3)) << (IDX_W + 2)) | (32'($urandom_range(0, ENTRIES - 1)) << 2)
               | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        bit          pt;
        logic [31:0] ptg, rpc;
        model_clear();
        go(1, 32'h100, 0, 0, 0, 0, 0, 0);
        go(1, 32'h100, 0, 0, 0, 0, 0, 0);
        go(0, 32'h100, 0, 0, 0, 0, 0, 0);
        chk("r036_taken", 32'(pred_taken), 32'd0);
        chk("r036_target", pred_target, 32'h104);
        // First taken resolve of 0x100 allocates and redirects to 0x80
        go(0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104);
        chk("r037_redirect", 32'(redirect), 32'd1);
        chk("r037_rpc", redirect_pc, 32'h80);
        chk("r037_count", mispredict_count, 32'd1);
        chk("r037_taken", 32'(pred_taken), 32'd1);
        chk("r037_target", pred_target, 32'h80);
        for (int i = 0; i < 4; i++) go(0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80);
        go(0, 32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80);
        chk("r038_rpc", redirect_pc, 32'h104);
        go(0, 32'h100, 1, 32'h100, 0, 32'h80, 0, 32'h104);
        chk("r038_taken", 32'(pred_taken), 32'd0);
        // 0x140 shares slot 0 with 0x100 and evicts it
        go(0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104);
        go(0, 32'h100, 1, 32'h140, 1, 32'h200, 0, 32'h144);
        go(0, 32'h100, 0, 0, 0, 0, 0, 0);
        chk("r039_alias_miss", pred_target, 32'h104);
        go(0, 32'h140, 0, 0, 0, 0, 0, 0);
        chk("r039_alias_hit", pred_target, 32'h200);
        go(0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104);
        // Same-cycle fetch and update: lookup sees 0x80, update lands next cycle
        go(0, 32'h100, 1, 32'h100, 1, 32'h90, 1, 32'h80);
        chk("r040_rpc", redirect_pc, 32'h90);
        go(0, 32'h100, 0, 0, 0, 0, 0, 0);
        chk("r040_target", pred_target, 32'h90);
        go(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
        chk("r032_wrap", pred_target, 32'h0);
        go(1, 32'h100, 1, 32'h100, 0, 32'h90, 1, 32'h90);
        chk("r041_redirect", 32'(redirect), 32'd0);
        chk("r041_count", mispredict_count, 32'd0);
        go(0, 32'h100, 0, 0, 0, 0, 0, 0);
        chk("r041_cleared", pred_target, 32'h104);

        for (int n = 0; n < 400; n++) begin
            rpc = rand_pc();
            if ($urandom_range(0, 3) != 0) begin
                model_pred(rpc, pt, ptg);
            end else begin
                pt  = 1'($urandom_range(0, 1));
                ptg = rand_pc();
            end
            resolve_is_branch = 1'b1;
            go($urandom_range(0, 63) == 0, rand_pc(), $urandom_range(0, 4) != 0, rpc,
               1'($urandom_range(0, 1)), rand_pc() & 32'hFFFF_FFFC, pt, ptg);
        end
        // Non-branch resolves must leave everything alone
        for (int n = 0; n < 20; n++) begin
            reset = 0; fetch_pc = rand_pc(); resolve_valid = 1; resolve_is_branch = 0;
            resolve_pc = rand_pc(); branch_result = 1; resolve_target = 32'h1234;
            resolve_pred_taken = 0; resolve_pred_target = 0;
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, 16, number of direct-mapped BHT/BTB entries; SHALL be a power of two, 2..256.
REQ-002 Parameter IDX_W, log2(ENTRIES), index width.
REQ-003 Port clock  in  1  single clock; all state SHALL update on its rising edge only.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port fetch_pc  in  32  PC being fetched this cycle.
REQ-006 Port pred_taken  out  1  prediction for fetch_pc; combinational.
REQ-007 Port pred_target  out  32  predicted next PC for fetch_pc; combinational.
REQ-008 Port resolve_valid  in  1  execute-stage instruction valid this cycle.
REQ-009 Port resolve_is_branch  in  1  the resolving instruction is a conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU).
REQ-010 Port resolve_pc  in  32  PC of the resolving branch.
REQ-011 Port branch_result  in  1  actual outcome from the branch comparator, 1 = taken.
REQ-012 Port resolve_target  in  32  computed taken target of the resolving branch.
REQ-013 Port resolve_pred_taken  in  1  pred_taken carried down the pipeline with the branch.
REQ-014 Port resolve_pred_target  in  32  pred_target carried down the pipeline with the branch.
REQ-015 Port redirect  out  1  registered one-cycle pulse: flush younger instructions, refetch.
REQ-016 Port redirect_pc  out  32  registered corrected fetch PC, valid when redirect=1.
REQ-017 Port mispredict_count  out  32  registered count of mispredicted branches.

Function
REQ-018 Entry state: valid (1), tag (32-IDX_W-2), target (32), ctr (2-bit saturating).
REQ-019 Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
REQ-020 Lookup hit = entry valid AND stored tag equal to fetch_pc tag.
REQ-021 pred_taken = hit AND ctr[1]; pred_target = stored target if pred_taken, else fetch_pc+4, modulo 2^32.
REQ-022 Update event = resolve_valid AND resolve_is_branch; no state changes without it.
REQ-023 Update on hit: ctr increments if branch_result=1, decrements if 0; saturates at 2'b11 and 2'b00; target overwritten with resolve_target when branch_result=1.
REQ-024 Update on miss with branch_result=1: allocate entry, valid=1, tag from resolve_pc, target=resolve_target, ctr=2'b10, replacing any previous occupant.
REQ-025 Update on miss with branch_result=0: no allocation; table unchanged.
REQ-026 actual_next = branch_result ? resolve_target : resolve_pc+4; predicted_next = resolve_pred_taken ? resolve_pred_target : resolve_pc+4.
REQ-027 Mispredict = update event AND actual_next != predicted_next; a correct direction with a wrong target counts as a mispredict.
REQ-028 On mispredict, the next edge sets redirect=1 and redirect_pc=actual_next; otherwise redirect=0 and redirect_pc holds its value.
REQ-029 Each mispredict increments mispredict_count by 1; it saturates at 0xFFFF_FFFF.
REQ-030 Fetch and update to the same index in the same cycle: the lookup returns pre-update contents, and the update becomes visible the following cycle.
REQ-031 Consecutive mispredicts on back-to-back cycles produce back-to-back redirect pulses, each carrying its own actual_next.
REQ-032 fetch_pc=0xFFFF_FFFC with no hit gives pred_target=0x0000_0000 (wrap-around).

Reset
REQ-033 While reset=1 at an edge: every valid=0, every ctr=2'b01, every target=0, redirect=0, redirect_pc=0, mispredict_count=0.
REQ-034 reset has priority over a simultaneous update event; the in-flight update and redirect are discarded.
REQ-035 After reset, pred_taken=0 and pred_target=fetch_pc+4 for all PCs until an allocation occurs.

Verification
REQ-036 Reset, then fetch_pc=0x100 -> pred_taken=0, pred_target=0x104, redirect=0, mispredict_count=0.
REQ-037 Resolve pc=0x100, branch_result=1, target=0x80, pred_taken=0 -> next cycle redirect=1, redirect_pc=0x80, count=1; fetch 0x100 then gives pred_taken=1, pred_target=0x80.
REQ-038 Four taken resolves of 0x100 predicted correctly -> ctr=11, no redirect; two not-taken resolves -> ctr=01, pred_taken=0, with one redirect (first not-taken) to 0x104.
REQ-039 Alias: allocate 0x100 taken, then resolve 0x140 taken (ENTRIES=16, same index) -> 0x100 misses and gives pred_target=0x104; 0x140 hits.
REQ-040 Correct direction, wrong target (pred_target=0x80, resolve_target=0x90, taken) -> redirect_pc=0x90, count increments, stored target becomes 0x90.
REQ-041 Mispredict with reset asserted in the same cycle -> redirect=0, count=0, table cleared on the next cycle.
